sumador_serial_ctrl: RTL and testbench
======================================

# sumador_serial_ctrl

Bit-serial addition controller. It accepts two N-bit operands and a carry-in on a start strobe, then sequences a single 1-bit full-adder cell (the team's `SumadorCompleto`) over N clock cycles, LSB first. It returns the N-bit sum, carry-out and signed overflow with a one-cycle done pulse. It trades latency for area in designs that need multi-bit addition but can afford one adder cell.

## Interface
Parameters:
- `N`, default 8: operand width. Legal range is 2..32. The bit counter is $clog2(N) bits wide.

Ports:
- `clk`  in  1  single clock; everything is sampled on the rising edge.
- `rst`  in  1  asynchronous, active-high reset. It dominates all other inputs.
- `inicio`  in  1  start request. It is only accepted in REPOSO.
- `a`  in  N  operand A. Sampled only on the accepting edge.
- `b`  in  N  operand B. Sampled only on the accepting edge.
- `cin`  in  1  carry-in. Sampled only on the accepting edge.
- `ocupado`  out  1  high while state != REPOSO.
- `listo`  out  1  one-cycle done pulse; high exactly while in FIN.
- `suma`  out  N  registered result.
- `cout`  out  1  registered carry-out of bit N-1.
- `desborde`  out  1  registered signed overflow: carry into bit N-1 XOR carry out of bit N-1.

## Operation
- States:
  - REPOSO: idle. `inicio`=1 loads shift registers rA←`a`, rB←`b`, carry register rC←`cin`, counter←0, then goes to SUMANDO.
  - SUMANDO: each edge feeds rA[0], rB[0], rC to the full-adder cell, then:
    - rC←cell carry-out;
    - rA and rB shift right by one;
    - cell sum bit shifts into the MSB of result shift register rS;
    - counter increments.
    - When counter==N-1, that edge is the last bit: `suma`←{cell sum, rS[N-1:1]}, `cout`←cell carry-out, `desborde`←rC XOR cell carry-out. Next state is FIN.
  - FIN: `listo`=1 for this one cycle. Next state is always REPOSO; `inicio` is ignored here.
- `inicio` is ignored while `ocupado`=1. Operand changes after acceptance do not affect the result.
- `suma`, `cout` and `desborde` change only on the final SUMANDO edge. They hold until the next operation completes. Partial results are never visible on the outputs.
- Arithmetic: unsigned result is {`cout`,`suma`} = `a`+`b`+`cin`, exact. `desborde` is the two's-complement overflow flag.
- Reset, including mid-operation: state←REPOSO; `ocupado`, `listo`, `suma`, `cout`, `desborde`, rA, rB, rS, rC and counter all←0. The in-flight operation is discarded and no `listo` is produced for it.

## Timing
- Accepting edge E0 (REPOSO, `inicio`=1). Edges E1..EN are SUMANDO. Result outputs update on EN. The FIN cycle follows EN, with `listo`=1 and `ocupado`=1. The edge EN+1 returns to REPOSO.
- Latency: N edges from acceptance to valid result, with `listo` asserted in the same cycle the result first appears.
- Throughput: one operation per N+2 cycles. The earliest next acceptance is at edge EN+2.
- `ocupado` rises after E0 and falls after EN+1.
- `inicio` held high continuously produces back-to-back operations every N+2 cycles.
- `rst` takes effect immediately, without waiting for a clock edge. Its deassertion is synchronous to the next edge.

## Test plan
- Reset: pulse `rst` asynchronously between edges. Required: `ocupado`=0, `listo`=0, `suma`=0x00, `cout`=0, `desborde`=0 immediately, before any clock edge.
- N=8, `a`=0x5A, `b`=0x3C, `cin`=0. Required: `listo` one cycle exactly 8 edges after acceptance, `suma`=0x96, `cout`=0, `desborde`=1.
- N=8, two operations:
  - `a`=0xFF, `b`=0x01, `cin`=0: `suma`=0x00, `cout`=1, `desborde`=0.
  - `a`=0x80, `b`=0x80, `cin`=0: `suma`=0x00, `cout`=1, `desborde`=1.
- N=8, `a`=0xFF, `b`=0xFF, `cin`=1. Required: `suma`=0xFF, `cout`=1, `desborde`=0. Previous outputs must hold unchanged until the final edge.
- `inicio` held high with `a`, `b` changing every cycle:
  - operations accepted only at E0, E10, E20, … (N=8);
  - each result matches the operands present at its own acceptance edge;
  - `listo` never asserted in consecutive cycles.
- Assert `rst` after the 4th SUMANDO edge of `a`=0x12, `b`=0x34. Required:
  - all outputs 0 immediately;
  - no `listo` produced;
  - a following `a`=0x01, `b`=0x02 yields `suma`=0x03, `cout`=0, with correct N+2 timing.

Source files
------------

// File: rtl/sumador_serial_ctrl.sv
// sumador_serial_ctrl
// Bit-serial adder controller. On an accepted start request it captures two
// N-bit operands and a carry-in. It then runs one 1-bit full-adder cell over N
// clock cycles, LSB first. It returns the sum, the carry-out and the signed
// overflow flag, together with a one-cycle done pulse.
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   inicio    start request, accepted only while idle
//   a, b      N-bit operands, sampled on the accepting edge
//   cin       carry-in, sampled on the accepting edge
//   ocupado   high while an operation is in flight (SUMANDO or FIN)
//   listo     one-cycle done pulse (FIN state)
//   suma      registered N-bit sum
//   cout      registered carry-out of bit N-1
//   desborde  registered two's-complement overflow flag
module sumador_serial_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inicio,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         ocupado,
  output logic         listo,
  output logic [N-1:0] suma,
  output logic         cout,
  output logic         desborde
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] ULTIMO_BIT = CW'(N - 1);

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    SUMANDO = 2'd1,
    FIN     = 2'd2
  } estado_t;

  estado_t estado, estado_sig;

  logic [N-1:0]  ra, rb;
  // Only N-1 partial sum bits are stored. The last bit comes straight from the
  // cell on the final edge.
  logic [N-2:0]  rs;
  logic          rc;
  logic [CW-1:0] cnt;

  logic          bit_suma, bit_carry, ultimo;

  // 1-bit full-adder cell: returns {carry, sum}
  function automatic logic [1:0] sumador_completo(input logic x, input logic y,
                                                  input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

  always_comb begin
    {bit_carry, bit_suma} = sumador_completo(ra[0], rb[0], rc);
  end

  assign ultimo  = (cnt == ULTIMO_BIT);
  assign ocupado = (estado != REPOSO);
  assign listo   = (estado == FIN);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado <= REPOSO;
    end else begin
      estado <= estado_sig;
    end
  end

  // Next-state logic
  always_comb begin
    estado_sig = estado;
    case (estado)
      REPOSO:  if (inicio) estado_sig = SUMANDO;
      SUMANDO: if (ultimo) estado_sig = FIN;
      FIN:     estado_sig = REPOSO;
      default: estado_sig = REPOSO;
    endcase
  end

  // Serial datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra       <= '0;
      rb       <= '0;
      rs       <= '0;
      rc       <= 1'b0;
      cnt      <= '0;
      suma     <= '0;
      cout     <= 1'b0;
      desborde <= 1'b0;
    end else begin
      case (estado)
        REPOSO: begin
          if (inicio) begin
            ra  <= a;
            rb  <= b;
            rc  <= cin;
            cnt <= '0;
          end
        end
        SUMANDO: begin
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          rc  <= bit_carry;
          rs  <= (N-1)'({bit_suma, rs} >> 1);
          cnt <= cnt + CW'(1);
          if (ultimo) begin
            // rc still holds the carry into the MSB at this point
            suma     <= {bit_suma, rs};
            cout     <= bit_carry;
            desborde <= rc ^ bit_carry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sumador_serial_ctrl.sv
module tb_sumador_serial_ctrl;

  logic       clk;
  logic       rst;
  logic       inicio;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       ocupado;
  logic       listo;
  logic [7:0] suma;
  logic       cout;
  logic       desborde;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] opa [0:29];
  logic [7:0] opb [0:29];

  sumador_serial_ctrl #(.N(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .inicio   (inicio),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .ocupado  (ocupado),
    .listo    (listo),
    .suma     (suma),
    .cout     (cout),
    .desborde (desborde)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start an operation from idle and follow it to completion.
  task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                        input logic vc, input logic [7:0] es, input logic ec,
                        input logic ed);
    logic [7:0] ps;
    logic       pc, pd, hold_ok, done;
    int         k, got;
    ps = suma; pc = cout; pd = desborde;
    hold_ok = 1'b1; done = 1'b0; got = -1; k = 0;
    @(negedge clk);
    a = va; b = vb; cin = vc; inicio = 1'b1;
    @(posedge clk);            // E0
    @(negedge clk);
    inicio = 1'b0;
    a = ~va; b = ~vb; cin = ~vc;
    while (!done && k < 20) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (k == 3) inicio = 1'b1;   // must be ignored while busy
      if (k == 4) inicio = 1'b0;
      if (listo === 1'b1) begin
        got  = k;
        done = 1'b1;
      end else if (suma !== ps || cout !== pc || desborde !== pd || ocupado !== 1'b1) begin
        hold_ok = 1'b0;
      end
    end
    chk({tag, "_latency"}, got, 8);
    chk({tag, "_hold"}, hold_ok, 1'b1);
    chk({tag, "_suma"}, suma, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_desborde"}, desborde, ed);
    chk({tag, "_ocupado_fin"}, ocupado, 1'b1);
    @(negedge clk);
    chk({tag, "_listo_off"}, listo, 1'b0);
    chk({tag, "_ocupado_off"}, ocupado, 1'b0);
  endtask

  initial begin
    logic [8:0] tot;
    logic       ok;
    int         e0;

    rst = 1'b1; inicio = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    for (int i = 0; i < 30; i++) begin
      opa[i] = 8'(i * 29 + 7);
      opb[i] = 8'(i * 53 + 200);
    end

    // Reset state, before any clock edge
    #1;
    chk("rst_ocupado", ocupado, 1'b0);
    chk("rst_listo", listo, 1'b0);
    chk("rst_suma", suma, 8'h00);
    chk("rst_cout", cout, 1'b0);
    chk("rst_desborde", desborde, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op("op5A3C", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);

    // Asynchronous reset pulse between edges clears the held result at once
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_suma", suma, 8'h00);
    chk("arst_desborde", desborde, 1'b0);
    chk("arst_ocupado", ocupado, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    run_op("opFF01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("op8080", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    run_op("opFFFF1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

    // inicio held high, operands changing every cycle
    @(negedge clk);
    a = opa[0]; b = opb[0]; cin = 1'b0; inicio = 1'b1;
    for (int e = 0; e < 30; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e % 10 == 8) begin
        e0  = e - 8;
        tot = {1'b0, opa[e0]} + {1'b0, opb[e0]};
        chk($sformatf("b2b_listo_%0d", e), listo, 1'b1);
        chk($sformatf("b2b_suma_%0d", e), suma, tot[7:0]);
        chk($sformatf("b2b_cout_%0d", e), cout, tot[8]);
        chk($sformatf("b2b_desb_%0d", e), desborde,
            (opa[e0][7] == opb[e0][7]) && (tot[7] != opa[e0][7]));
      end else begin
        chk($sformatf("b2b_listo_%0d", e), listo, 1'b0);
      end
      chk($sformatf("b2b_ocupado_%0d", e), ocupado, (e % 10 == 9) ? 1'b0 : 1'b1);
      if (e < 29) begin
        a = opa[e + 1]; b = opb[e + 1];
      end else begin
        inicio = 1'b0;
      end
    end

    // Reset in the middle of an operation
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; inicio = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inicio = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_ocupado", ocupado, 1'b0);
    chk("mid_listo", listo, 1'b0);
    chk("mid_suma", suma, 8'h00);
    chk("mid_cout", cout, 1'b0);
    chk("mid_desborde", desborde, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    ok = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (listo !== 1'b0 || ocupado !== 1'b0) ok = 1'b0;
    end
    chk("mid_no_listo", ok, 1'b1);

    run_op("op0102", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
